// File: rtl/human_det_pkg.sv
// Shared types and helpers for the human detector pixel pipeline:
// FSM state encoding, default frame geometry and edge-detect functions.
package human_det_pkg;

   localparam int DEF_H_ACTIVE = 1280;
   localparam int DEF_V_ACTIVE = 720;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_LATCH  = 2'd2
   } frame_state_e;

   function automatic logic rise_edge(input logic cur, input logic prev);
      return cur & ~prev;
   endfunction

   function automatic logic fall_edge(input logic cur, input logic prev);
      return ~cur & prev;
   endfunction

endpackage

// File: rtl/bbox_coord_counter.sv
// Pixel coordinate generator for the bounding-box extractor: vsync/href edge
// detection and saturating column/row counters with a pixel-accept qualifier.
module bbox_coord_counter
   import human_det_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int X_W      = 11,
   parameter int Y_W      = 10
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           vsync_i,
   input  logic           href_i,
   input  logic           clken_i,
   output logic [X_W-1:0] x_o,
   output logic [Y_W-1:0] y_o,
   output logic           pixel_accept_o,
   output logic           vs_rise_o,
   output logic           vs_fall_o
);

   localparam logic [X_W-1:0] X_END = X_W'(H_ACTIVE);
   localparam logic [Y_W-1:0] Y_END = Y_W'(V_ACTIVE);

   logic           vsync_q;
   logic           href_q;
   logic [X_W-1:0] x_q, x_d, x_base_s;
   logic [Y_W-1:0] y_q, y_d, y_base_s;
   logic           href_fall_s;

   // Edge detection against the registered copies of vsync and href.
   always_comb begin
      vs_rise_o   = rise_edge(vsync_i, vsync_q);
      vs_fall_o   = fall_edge(vsync_i, vsync_q);
      href_fall_s = fall_edge(href_i, href_q);
   end

   // Coordinates restart on every vsync rise, so a pixel on that edge sees (0,0).
   always_comb begin
      if (vs_rise_o) begin
         x_base_s = {X_W{1'b0}};
         y_base_s = {Y_W{1'b0}};
      end else begin
         x_base_s = x_q;
         y_base_s = y_q;
      end

      x_d = x_base_s;
      y_d = y_base_s;
      if (href_fall_s) begin
         x_d = {X_W{1'b0}};
         y_d = (y_base_s < Y_END) ? (y_base_s + Y_W'(1'b1)) : y_base_s;
      end else if (href_i && clken_i) begin
         x_d = (x_base_s < X_END) ? (x_base_s + X_W'(1'b1)) : x_base_s;
      end else begin
         x_d = x_base_s;
      end

      x_o            = x_base_s;
      y_o            = y_base_s;
      pixel_accept_o = vsync_i & href_i & clken_i & (x_base_s < X_END) & (y_base_s < Y_END);
   end

   // vsync_q resets high so a frame already in progress at reset release
   // does not look like a rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q <= 1'b1;
         href_q  <= 1'b0;
         x_q     <= {X_W{1'b0}};
         y_q     <= {Y_W{1'b0}};
      end else begin
         vsync_q <= vsync_i;
         href_q  <= href_i;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

endmodule

// File: rtl/human_bbox_extract.sv
// Frame-level bounding-box extractor: accumulates min/max coordinates and the
// count of foreground pixels per frame and publishes one registered result.
module human_bbox_extract
   import human_det_pkg::*;
#(
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int X_W        = 11,
   parameter int Y_W        = 10,
   parameter int CNT_W      = 21,
   parameter int MIN_PIXELS = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             per_frame_vsync_i,
   input  logic             per_frame_href_i,
   input  logic             per_frame_clken_i,
   input  logic             per_img_bit_i,
   output logic [X_W-1:0]   box_x_min_o,
   output logic [X_W-1:0]   box_x_max_o,
   output logic [Y_W-1:0]   box_y_min_o,
   output logic [Y_W-1:0]   box_y_max_o,
   output logic [CNT_W-1:0] box_pix_cnt_o,
   output logic             box_valid_o,
   output logic             box_update_o
);

   localparam logic [X_W-1:0]   X_LAST  = X_W'(H_ACTIVE - 1);
   localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

   frame_state_e     state_q, state_d;
   logic [X_W-1:0]   x_s;
   logic [Y_W-1:0]   y_s;
   logic             accept_s, vs_rise_s, vs_fall_s;
   logic             frame_start_s, take_s;

   logic [X_W-1:0]   x_min_q, x_min_d, x_max_q, x_max_d, x_min_b_s, x_max_b_s;
   logic [Y_W-1:0]   y_min_q, y_min_d, y_max_q, y_max_d, y_min_b_s, y_max_b_s;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_b_s;

   logic [X_W-1:0]   box_x_min_q, box_x_min_d, box_x_max_q, box_x_max_d;
   logic [Y_W-1:0]   box_y_min_q, box_y_min_d, box_y_max_q, box_y_max_d;
   logic [CNT_W-1:0] box_pix_cnt_q, box_pix_cnt_d;
   logic             box_valid_q, box_valid_d;
   logic             box_update_q, box_update_d;

   bbox_coord_counter #(
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE),
      .X_W      (X_W),
      .Y_W      (Y_W)
   ) u_coord (
      .clk            (clk),
      .rst_n          (rst_n),
      .vsync_i        (per_frame_vsync_i),
      .href_i         (per_frame_href_i),
      .clken_i        (per_frame_clken_i),
      .x_o            (x_s),
      .y_o            (y_s),
      .pixel_accept_o (accept_s),
      .vs_rise_o      (vs_rise_s),
      .vs_fall_o      (vs_fall_s)
   );

   // Frame FSM; a rise while in LATCH is intentionally not seen.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (vs_rise_s) state_d = ST_ACTIVE;
            else           state_d = ST_IDLE;
         end
         ST_ACTIVE: begin
            if (vs_fall_s) state_d = ST_LATCH;
            else           state_d = ST_ACTIVE;
         end
         ST_LATCH: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Accumulators: reload at frame start, then merge any foreground pixel.
   always_comb begin
      frame_start_s = (state_q == ST_IDLE) && vs_rise_s;
      take_s        = accept_s && per_img_bit_i && (frame_start_s || (state_q == ST_ACTIVE));

      if (frame_start_s) begin
         x_min_b_s = X_LAST;
         x_max_b_s = {X_W{1'b0}};
         y_min_b_s = Y_LAST;
         y_max_b_s = {Y_W{1'b0}};
         cnt_b_s   = {CNT_W{1'b0}};
      end else begin
         x_min_b_s = x_min_q;
         x_max_b_s = x_max_q;
         y_min_b_s = y_min_q;
         y_max_b_s = y_max_q;
         cnt_b_s   = cnt_q;
      end

      x_min_d = (take_s && (x_s < x_min_b_s)) ? x_s : x_min_b_s;
      x_max_d = (take_s && (x_s > x_max_b_s)) ? x_s : x_max_b_s;
      y_min_d = (take_s && (y_s < y_min_b_s)) ? y_s : y_min_b_s;
      y_max_d = (take_s && (y_s > y_max_b_s)) ? y_s : y_max_b_s;
      cnt_d   = (take_s && !(&cnt_b_s)) ? (cnt_b_s + CNT_W'(1'b1)) : cnt_b_s;
   end

   // Result registers load only in LATCH and otherwise hold.
   always_comb begin
      box_x_min_d   = box_x_min_q;
      box_x_max_d   = box_x_max_q;
      box_y_min_d   = box_y_min_q;
      box_y_max_d   = box_y_max_q;
      box_pix_cnt_d = box_pix_cnt_q;
      box_valid_d   = box_valid_q;
      box_update_d  = 1'b0;
      if (state_q == ST_LATCH) begin
         box_pix_cnt_d = cnt_q;
         box_update_d  = 1'b1;
         if (cnt_q >= MIN_CNT) begin
            box_x_min_d = x_min_q;
            box_x_max_d = x_max_q;
            box_y_min_d = y_min_q;
            box_y_max_d = y_max_q;
            box_valid_d = 1'b1;
         end else begin
            box_x_min_d = {X_W{1'b0}};
            box_x_max_d = {X_W{1'b0}};
            box_y_min_d = {Y_W{1'b0}};
            box_y_max_d = {Y_W{1'b0}};
            box_valid_d = 1'b0;
         end
      end else begin
         box_update_d = 1'b0;
      end
   end

   // State, accumulator and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         x_min_q       <= {X_W{1'b0}};
         x_max_q       <= {X_W{1'b0}};
         y_min_q       <= {Y_W{1'b0}};
         y_max_q       <= {Y_W{1'b0}};
         cnt_q         <= {CNT_W{1'b0}};
         box_x_min_q   <= {X_W{1'b0}};
         box_x_max_q   <= {X_W{1'b0}};
         box_y_min_q   <= {Y_W{1'b0}};
         box_y_max_q   <= {Y_W{1'b0}};
         box_pix_cnt_q <= {CNT_W{1'b0}};
         box_valid_q   <= 1'b0;
         box_update_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         x_min_q       <= x_min_d;
         x_max_q       <= x_max_d;
         y_min_q       <= y_min_d;
         y_max_q       <= y_max_d;
         cnt_q         <= cnt_d;
         box_x_min_q   <= box_x_min_d;
         box_x_max_q   <= box_x_max_d;
         box_y_min_q   <= box_y_min_d;
         box_y_max_q   <= box_y_max_d;
         box_pix_cnt_q <= box_pix_cnt_d;
         box_valid_q   <= box_valid_d;
         box_update_q  <= box_update_d;
      end
   end

   assign box_x_min_o   = box_x_min_q;
   assign box_x_max_o   = box_x_max_q;
   assign box_y_min_o   = box_y_min_q;
   assign box_y_max_o   = box_y_max_q;
   assign box_pix_cnt_o = box_pix_cnt_q;
   assign box_valid_o   = box_valid_q;
   assign box_update_o  = box_update_q;

endmodule

// File: tb/tb_human_bbox_extract.sv
// Self-checking bench for human_bbox_extract on a small 8x6 frame: directed
// vector table, hand-written corner sequences and randomized frames vs a model.
module tb_human_bbox_extract;

   localparam int H    = 8;
   localparam int V    = 6;
   localparam int MINP = 2;
   localparam int XW   = 11;
   localparam int YW   = 10;
   localparam int CW   = 21;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          vs = 1'b0, hr = 1'b0, ck = 1'b0, bitv = 1'b0;
   logic [XW-1:0] box_x_min, box_x_max;
   logic [YW-1:0] box_y_min, box_y_max;
   logic [CW-1:0] box_pix_cnt;
   logic          box_valid, box_update;

   always #5 clk = ~clk;

   human_bbox_extract #(
      .H_ACTIVE(H), .V_ACTIVE(V), .X_W(XW), .Y_W(YW), .CNT_W(CW), .MIN_PIXELS(MINP)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .per_frame_vsync_i (vs),
      .per_frame_href_i  (hr),
      .per_frame_clken_i (ck),
      .per_img_bit_i     (bitv),
      .box_x_min_o       (box_x_min),
      .box_x_max_o       (box_x_max),
      .box_y_min_o       (box_y_min),
      .box_y_max_o       (box_y_max),
      .box_pix_cnt_o     (box_pix_cnt),
      .box_valid_o       (box_valid),
      .box_update_o      (box_update)
   );

   typedef struct {
      string name;
      int    nl, np;
      int    rx0, rx1, ry0, ry1;
      int    p0x, p0y, p1x, p1y;
      bit    gaps;
      int    exmin, exmax, eymin, eymax, ecnt;
      bit    evalid;
   } vec_t;

   vec_t vecs[5];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   img [0:11][0:11];
   int   m_xmin, m_xmax, m_ymin, m_ymax, m_cnt;
   bit   m_valid;
   logic [31:0] c_xmin, c_xmax, c_ymin, c_ymax, c_cnt, c_valid;
   int   nupd, first;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_img();
      for (int y = 0; y < 12; y++)
         for (int x = 0; x < 12; x++)
            img[y][x] = 1'b0;
   endtask

   // Reference: box of foreground inside the active window of the image.
   task automatic run_model(input int nl, input int np);
      int c, x0, x1, y0, y1;
      c = 0; x0 = H - 1; x1 = 0; y0 = V - 1; y1 = 0;
      for (int y = 0; y < nl && y < V; y++)
         for (int x = 0; x < np && x < H; x++)
            if (img[y][x]) begin
               c++;
               if (x < x0) x0 = x;
               if (x > x1) x1 = x;
               if (y < y0) y0 = y;
               if (y > y1) y1 = y;
            end
      m_cnt   = c;
      m_valid = (c >= MINP);
      m_xmin  = m_valid ? x0 : 0;
      m_xmax  = m_valid ? x1 : 0;
      m_ymin  = m_valid ? y0 : 0;
      m_ymax  = m_valid ? y1 : 0;
   endtask

   // Streams img line by line; optionally pulses reset for 3 cycles mid-frame.
   task automatic send_frame(input int nl, input int np, input bit gaps, input int lead, input int rst_line);
      vs = 1'b1; hr = 1'b0; ck = 1'b0; bitv = 1'b0;
      repeat (lead) tick();
      for (int y = 0; y < nl; y++) begin
         hr = 1'b1;
         for (int x = 0; x < np; x++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
               ck = 1'b0; bitv = 1'($urandom_range(0, 1));
               tick();
            end
            ck = 1'b1; bitv = img[y][x];
            if (y == rst_line && x == 1) begin
               rst_n = 1'b0;
               #1;
               check("rst_xmin", 32'(box_x_min), 32'd0);
               check("rst_xmax", 32'(box_x_max), 32'd0);
               check("rst_ymax", 32'(box_y_max), 32'd0);
               check("rst_cnt", 32'(box_pix_cnt), 32'd0);
               check("rst_valid", 32'(box_valid), 32'd0);
               repeat (3) tick();
               rst_n = 1'b1;
            end
            tick();
         end
         hr = 1'b0; ck = 1'($urandom_range(0, 1)); bitv = 1'b1;
         tick();
         ck = 1'b0; bitv = 1'b0;
         tick();
      end
   endtask

   // Drops vsync and watches a bounded window for the update strobe.
   task automatic finish_frame(output int nu, output int fc);
      vs = 1'b0; hr = 1'b0; ck = 1'b0; bitv = 1'b0;
      nu = 0; fc = 0;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (box_update === 1'b1) begin
            nu++;
            if (fc == 0) begin
               fc = c;
               c_xmin = 32'(box_x_min); c_xmax = 32'(box_x_max);
               c_ymin = 32'(box_y_min); c_ymax = 32'(box_y_max);
               c_cnt  = 32'(box_pix_cnt); c_valid = 32'(box_valid);
            end
         end
      end
      if (nu == 0) begin
         c_xmin = 32'(box_x_min); c_xmax = 32'(box_x_max);
         c_ymin = 32'(box_y_min); c_ymax = 32'(box_y_max);
         c_cnt  = 32'(box_pix_cnt); c_valid = 32'(box_valid);
      end
   endtask

   task automatic check_box(input string tag, input int nu, input int fc, input int exp_upd,
                            input int xmn, input int xmx, input int ymn, input int ymx,
                            input int cnt, input int vld);
      check({tag, "_upd_count"}, 32'(nu), 32'(exp_upd));
      if (exp_upd != 0) check({tag, "_upd_cycle"}, 32'(fc), 32'd2);
      check({tag, "_xmin"}, c_xmin, 32'(xmn));
      check({tag, "_xmax"}, c_xmax, 32'(xmx));
      check({tag, "_ymin"}, c_ymin, 32'(ymn));
      check({tag, "_ymax"}, c_ymax, 32'(ymx));
      check({tag, "_cnt"}, c_cnt, 32'(cnt));
      check({tag, "_valid"}, c_valid, 32'(vld));
   endtask

   initial begin
      vecs[0] = '{"rect",   6,  8, 3, 5, 2, 3, -1, -1, -1, -1, 1'b0, 3, 5, 2, 3, 6, 1'b1};
      vecs[1] = '{"zero",   6,  8, 1, 0, 1, 0, -1, -1, -1, -1, 1'b0, 0, 0, 0, 0, 0, 1'b0};
      vecs[2] = '{"single", 6,  8, 1, 0, 1, 0,  4,  1, -1, -1, 1'b0, 0, 0, 0, 0, 1, 1'b0};
      vecs[3] = '{"corners",6,  8, 1, 0, 1, 0,  0,  0,  7,  5, 1'b1, 0, 7, 0, 5, 2, 1'b1};
      vecs[4] = '{"outside",7, 10, 8, 9, 0, 5,  2,  6,  9,  6, 1'b0, 0, 0, 0, 0, 0, 1'b0};

      // Reset state.
      repeat (3) tick();
      check("reset_xmin", 32'(box_x_min), 32'd0);
      check("reset_xmax", 32'(box_x_max), 32'd0);
      check("reset_ymin", 32'(box_y_min), 32'd0);
      check("reset_ymax", 32'(box_y_max), 32'd0);
      check("reset_cnt", 32'(box_pix_cnt), 32'd0);
      check("reset_valid", 32'(box_valid), 32'd0);
      check("reset_update", 32'(box_update), 32'd0);
      rst_n = 1'b1;
      repeat (2) tick();

      for (int i = 0; i < 5; i++) begin
         clear_img();
         for (int y = 0; y < 12; y++)
            for (int x = 0; x < 12; x++)
               img[y][x] = (x >= vecs[i].rx0 && x <= vecs[i].rx1 && y >= vecs[i].ry0 && y <= vecs[i].ry1) ||
                           (x == vecs[i].p0x && y == vecs[i].p0y) || (x == vecs[i].p1x && y == vecs[i].p1y);
         send_frame(vecs[i].nl, vecs[i].np, vecs[i].gaps, 2, -1);
         finish_frame(nupd, first);
         check_box(vecs[i].name, nupd, first, 1, vecs[i].exmin, vecs[i].exmax, vecs[i].eymin,
                   vecs[i].eymax, vecs[i].ecnt, 32'(vecs[i].evalid));
      end

      // Foreground pixel on the same cycle as the vsync rise is counted.
      clear_img();
      img[0][0] = 1'b1;
      img[1][2] = 1'b1;
      send_frame(3, 4, 1'b0, 0, -1);
      finish_frame(nupd, first);
      check_box("start_edge", nupd, first, 1, 0, 2, 0, 1, 2, 1);

      // Reset mid-frame: frame discarded, outputs stay cleared.
      clear_img();
      img[1][1] = 1'b1;
      img[1][2] = 1'b1;
      send_frame(6, 8, 1'b0, 2, 2);
      finish_frame(nupd, first);
      check_box("mid_reset", nupd, first, 0, 0, 0, 0, 0, 0, 0);
      send_frame(6, 8, 1'b0, 2, -1);
      finish_frame(nupd, first);
      check_box("after_reset", nupd, first, 1, 1, 2, 1, 1, 2, 1);

      // Randomized frames against the reference model.
      for (int r = 0; r < 14; r++) begin
         int nl, np, dens;
         bit gaps;
         nl   = $urandom_range(1, 8);
         np   = $urandom_range(1, 10);
         dens = (r % 4 == 0) ? 4 : $urandom_range(5, 60);
         gaps = 1'($urandom_range(0, 1));
         clear_img();
         for (int y = 0; y < nl; y++)
            for (int x = 0; x < np; x++)
               img[y][x] = ($urandom_range(0, 99) < dens);
         run_model(nl, np);
         send_frame(nl, np, gaps, ($urandom_range(0, 1) == 0) ? 0 : 2, -1);
         finish_frame(nupd, first);
         check_box($sformatf("rand%0d", r), nupd, first, 1, m_xmin, m_xmax, m_ymin, m_ymax,
                   m_cnt, 32'(m_valid));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/human_bbox_extract.md
# human_bbox_extract

Frame-level bounding-box extractor for the human detector, placed directly downstream of the binary dilation stage. It consumes the dilated 1-bit foreground stream with its vsync/href/clken qualifiers and tracks per-pixel coordinates. For each frame it accumulates the min/max column and row of foreground pixels plus their count. At frame end it publishes one registered box result with a one-cycle update strobe for the overlay/stitching logic.

## Interface
- H_ACTIVE, 1280, active pixels per line; pixels beyond this column are ignored
- V_ACTIVE, 720, active lines per frame; lines beyond this are ignored
- X_W, 11, column coordinate width (≥ clog2(H_ACTIVE))
- Y_W, 10, row coordinate width (≥ clog2(V_ACTIVE))
- CNT_W, 21, foreground pixel counter width
- MIN_PIXELS, 64, minimum foreground count for a valid box
- clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- per_frame_vsync  in  1  frame window, high during active frame
- per_frame_href  in  1  line window, high during active line
- per_frame_clken  in  1  pixel qualifier
- per_img_bit  in  1  dilated foreground bit (1 = foreground)
- box_x_min / box_x_max  out  X_W  box columns, inclusive
- box_y_min / box_y_max  out  Y_W  box rows, inclusive
- box_pix_cnt  out  CNT_W  foreground pixels in last frame
- box_valid  out  1  box_pix_cnt ≥ MIN_PIXELS
- box_update  out  1  one-cycle strobe, new result on outputs

## Operation
- Reset: all outputs 0, FSM IDLE, counters and accumulators cleared.
- FSM states IDLE → ACTIVE → LATCH → IDLE. IDLE→ACTIVE on vsync rising edge (vsync=1, vsync_r=0). ACTIVE→LATCH on vsync falling edge. LATCH→IDLE unconditionally after one cycle.
- Frame start (the IDLE→ACTIVE edge): x_cnt=0, y_cnt=0, x_min=H_ACTIVE-1, x_max=0, y_min=V_ACTIVE-1, y_max=0, cnt=0.
- Accepted pixel: vsync=1 & href=1 & clken=1, in ACTIVE or on the frame-start edge, x_cnt<H_ACTIVE, y_cnt<V_ACTIVE. An accepted pixel on the frame-start edge is merged into the freshly cleared values.
- On an accepted pixel with per_img_bit=1: update min/max with (x_cnt, y_cnt) and increment cnt, which saturates at all-ones.
- x_cnt increments per clken pixel while href=1 and holds at H_ACTIVE. Line end (href falling edge): x_cnt=0, y_cnt+1, holding at V_ACTIVE.
- clken gaps inside a line do not advance x_cnt.
- LATCH: register cnt into box_pix_cnt. If cnt ≥ MIN_PIXELS, register coordinates and set box_valid=1. Otherwise coordinates=0 and box_valid=0.
- Outputs hold until the next LATCH.
- Pixels with vsync=0 are never counted. A pixel in the same cycle as the vsync falling edge is therefore excluded.
- Reset release with vsync already high: the FSM stays IDLE until a genuine rising edge, so the partial frame is discarded with no update.
- Back-to-back frames: a rising edge during LATCH is missed and that frame is skipped. Upstream guarantees ≥2 cycles of vsync low.

## Timing
- Edge detection uses one registered copy each of vsync and href.
- Per-pixel accumulation takes effect at the sampling edge, one cycle.
- box_* and box_update change at the second clk edge after the first cycle sampling vsync=0. box_update is high for exactly that one cycle.
- No backpressure. Inputs are sampled every cycle.

## Structure
- Shared package human_det_pkg holds:
  - FSM state enum (IDLE, ACTIVE, LATCH);
  - default H_ACTIVE/V_ACTIVE;
  - the edge-detect helper functions shared with the dilation/erosion stages.
- One sub-module, bbox_coord_counter: vsync/href edge detection plus x_cnt/y_cnt generation with saturation, outputting x, y and pixel_accept. Min/max, count and FSM live in the top.

## Test plan
Bench parameters: H_ACTIVE=8, V_ACTIVE=6, MIN_PIXELS=2.
- Foreground at rows 2–3, cols 3–5, rest 0 → x_min=3, x_max=5, y_min=2, y_max=3, cnt=6, valid=1; single box_update 2 cycles after vsync falls.
- All-zero frame → cnt=0, valid=0, all coords 0, box_update still pulses once.
- Single foreground pixel at (4,1) → cnt=1, valid=0, coords 0.
- Foreground only at (0,0) and (7,5), with random clken gaps → x 0..7, y 0..5, cnt=2, valid=1.
- Line of 10 clken pixels with foreground only at cols 8–9, plus a 7th line with foreground → ignored: cnt=0, valid=0.
- Assert rst_n mid-frame for 3 cycles → outputs 0 immediately, no update for that frame; next full frame with box (1..2, 1..1) reported correctly.
